fetch_stage: RTL

Instruction-fetch stage of the pipelined LEGv8 processor.
- Owns the program counter and drives the instruction ROM address.
- Captures the returned 32-bit instruction together with its PC into the IF/ID pipeline register.
- Handles stall and branch-redirect requests from the later stages.
- Sits directly upstream of the decode stage and directly around the combinational instruction memory (7-bit word address, 32-bit data).

---
 rtl/fetch_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the pipelined LEGv8 processor.
//
// This stage owns the program counter and drives the combinational
// instruction ROM. Each fetched word is captured into the IF/ID pipeline
// register together with its PC. It also handles stall and branch-redirect
// requests that come from later stages.
//
// Optional feature macro: FETCH_FLUSH_EN
//   defined   : branch_taken flushes IF/ID to a NOP bubble (valid_D = 0),
//               overriding stall_F; pc_D holds.
//   undefined : branch_taken redirects the PC only. The wrong-path
//               instruction proceeds, because software schedules delay slots.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   stall_F        hold PC, IF/ID and fetch counter
//   branch_taken   redirect request; wins over stall_F for the PC
//   branch_target  redirect byte address; bits [1:0] are ignored
//   imem_addr      ROM word address = PC[IMEM_AW+1:2]
//   imem_q         ROM data, combinational from imem_addr
//   pc_F           current PC
//   pc_D, instr_D  IF/ID PC and instruction
//   valid_D        IF/ID holds a real fetched instruction
//   halt_D         IF/ID holds CBZ XZR self-loop (valid only)
//   fetch_count    instructions loaded into IF/ID since reset, saturating
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int          N         = 64,
  parameter int          IMEM_AW   = 7,
  parameter logic [31:0] NOP_INSTR = 32'h8b1f03ff
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               branch_taken,
  input  logic [N-1:0]       branch_target,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_q,
  output logic [N-1:0]       pc_F,
  output logic [N-1:0]       pc_D,
  output logic [31:0]        instr_D,
  output logic               valid_D,
  output logic               halt_D,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] HALT_INSTR = 32'hb400001f;

  logic [N-1:0] pc_q,       pc_d;
  logic [N-1:0] ifid_pc_q,  ifid_pc_d;
  logic [31:0]  ifid_ins_q, ifid_ins_d;
  logic         ifid_vld_q, ifid_vld_d;
  logic [31:0]  count_q,    count_d;
  logic         ifid_load;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_ins_d = ifid_ins_q;
    ifid_vld_d = ifid_vld_q;
    ifid_load  = 1'b0;

    // A redirect is never lost, even under stall. The target is forced to
    // word alignment.
    if (branch_taken)
      pc_d = branch_target & ~N'(3);
    else if (!stall_F)
      pc_d = pc_q + N'(4);

`ifdef FETCH_FLUSH_EN
    if (branch_taken) begin
      ifid_ins_d = NOP_INSTR;
      ifid_vld_d = 1'b0;
    end else
`endif
    if (!stall_F) begin
      ifid_pc_d  = pc_q;
      ifid_ins_d = imem_q;
      ifid_vld_d = 1'b1;
      ifid_load  = 1'b1;
    end

    // Count real loads only, and saturate at all-ones.
    count_d = count_q;
    if (ifid_load && (count_q != '1))
      count_d = count_q + 32'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      ifid_pc_q  <= '0;
      ifid_ins_q <= NOP_INSTR;
      ifid_vld_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_vld_q <= ifid_vld_d;
      count_q    <= count_d;
    end
  end

  // PCs beyond the ROM size alias back into it by design.
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign pc_F        = pc_q;
  assign pc_D        = ifid_pc_q;
  assign instr_D     = ifid_ins_q;
  assign valid_D     = ifid_vld_q;
  assign halt_D      = ifid_vld_q && (ifid_ins_q == HALT_INSTR);
  assign fetch_count = count_q;

endmodule
